// File: rtl/uart_alu_host.sv
// -----------------------------------------------------------------------------
// uart_alu_host
//
// Host-side initiator for the UART ALU link. One accepted command is sent on
// sci_tx as three back-to-back 8N1 bytes (A, B, then CTRL = {4'b0, cs, cin}).
// The block then waits for the one-byte result on sci_rx, with a timeout.
// The result is reported as a single-cycle rsp_valid pulse carrying a status
// code.
//
// Parameters
//   BAUD_DIV     clk cycles per UART bit (must be >= 4)
//   TIMEOUT_CYC  cycles allowed from the end of the CTRL stop bit to the
//                detection of the response start bit
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   cmd_valid/ready   command handshake; ready is high only while idle
//   cmd_a, cmd_b      operands A and B
//   cmd_cs, cmd_cin   ALU operation select and carry in
//   sci_tx            UART line to the ALU board (idle high)
//   sci_rx            UART line from the ALU board (asynchronous)
//   rsp_valid         one-cycle pulse: rsp_data / rsp_err are valid
//   rsp_data          received result, held until the next rsp_valid
//   rsp_err           00 ok, 01 timeout, 10 framing error (stop bit 0)
//   busy              inverse of cmd_ready
// -----------------------------------------------------------------------------
module uart_alu_host #(
   parameter int BAUD_DIV    = 5208,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_a,
   input  logic [7:0] cmd_b,
   input  logic [2:0] cmd_cs,
   input  logic       cmd_cin,
   output logic       sci_tx,
   input  logic       sci_rx,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic [1:0] rsp_err,
   output logic       busy
);

   // ---------------------------------------------------------------------------
   // Constants
   // ---------------------------------------------------------------------------
   localparam int BW = $clog2(BAUD_DIV);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   // The start bit is sampled half a bit after the falling edge, so every later
   // sample lands near the middle of its bit.
   localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYC);

   localparam logic [3:0] BIT_STOP_PREV = 4'd8;   // last data bit of a frame
   localparam logic [3:0] BIT_STOP      = 4'd9;   // stop bit of a frame

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_FRAME   = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TX_A,
      S_TX_B,
      S_TX_C,
      S_WAIT_RSP,
      S_RX_BYTE,
      S_DONE
   } state_e;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_e          r_state;
   logic [7:0]      r_a;
   logic [7:0]      r_b;
   logic [7:0]      r_ctrl;
   logic [BW-1:0]   r_baud_cnt;     // cycles elapsed within the current bit
   logic [3:0]      r_bit_idx;      // frame bit: 0 start, 1..8 data, 9 stop
   logic [TW-1:0]   r_tmo_cnt;      // cycles spent waiting for the response
   logic [7:0]      r_rx_shift;
   logic            r_sci_tx;
   logic            r_cmd_ready;
   logic            r_rsp_valid;
   logic [7:0]      r_rsp_data;
   logic [1:0]      r_rsp_err;

   logic            r_rx_meta;
   logic            r_rx_sync;
   logic            r_rx_prev;

   // ---------------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------------
   logic [7:0]      w_tx_byte;
   logic            w_next_tx_bit;
   logic            w_baud_tick;
   logic            w_rx_tick;
   logic            w_rx_fall;
   logic            w_tmo_hit;

   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      w_tx_byte = r_ctrl;
      case (r_state)
         S_TX_A:  w_tx_byte = r_a;
         S_TX_B:  w_tx_byte = r_b;
         default: w_tx_byte = r_ctrl;
      endcase
   end

   // Level of the frame bit that follows the current one. From bit index 0..7
   // the next bit is data bit r_bit_idx; after d7 comes the stop bit.
   assign w_next_tx_bit = (r_bit_idx == BIT_STOP_PREV) ? 1'b1 : w_tx_byte[r_bit_idx[2:0]];

   assign w_baud_tick = (r_baud_cnt == BAUD_LAST);
   assign w_rx_tick   = (r_bit_idx == 4'd0) ? (r_baud_cnt == HALF_LAST)
                                            : (r_baud_cnt == BAUD_LAST);
   assign w_rx_fall   = r_rx_prev & ~r_rx_sync;
   // ">=" rather than "==": the counter keeps running while a glitch is being
   // qualified, so it may already be past the limit on the return to WAIT_RSP.
   assign w_tmo_hit   = (r_tmo_cnt >= TMO_LAST);

   // ---------------------------------------------------------------------------
   // sci_rx synchroniser and edge history
   // ---------------------------------------------------------------------------
   // NOTE: these flops reset to 1, the idle level of the line. Resetting them to
   // 0 would present a fake falling edge the first time the line is watched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= sci_rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   // ---------------------------------------------------------------------------
   // Main FSM: command capture, transmitter, receiver and response reporting
   // ---------------------------------------------------------------------------
   // NOTE: all state here uses non-blocking assignments. Every branch then reads
   // the values from before the edge, and a later assignment in the block
   // overrides an earlier default.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a         <= 8'h00;
         r_b         <= 8'h00;
         r_ctrl      <= 8'h00;
         r_baud_cnt  <= '0;
         r_bit_idx   <= 4'd0;
         r_tmo_cnt   <= '0;
         r_rx_shift  <= 8'h00;
         r_sci_tx    <= 1'b1;
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= 8'h00;
         r_rsp_err   <= ERR_OK;
      end else begin
         r_rsp_valid <= 1'b0;

         // The timeout runs from WAIT_RSP entry across any glitch qualification
         // in RX_BYTE. It saturates instead of wrapping.
         if ((r_state == S_WAIT_RSP || r_state == S_RX_BYTE) && (r_tmo_cnt != TMO_MAX)) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
         end

         case (r_state)
            S_IDLE: begin
               if (cmd_valid && r_cmd_ready) begin
                  r_a         <= cmd_a;
                  r_b         <= cmd_b;
                  r_ctrl      <= {4'b0000, cmd_cs, cmd_cin};
                  r_sci_tx    <= 1'b0;            // start bit of A
                  r_baud_cnt  <= '0;
                  r_bit_idx   <= 4'd0;
                  r_cmd_ready <= 1'b0;
                  r_state     <= S_TX_A;
               end
            end

            S_TX_A, S_TX_B, S_TX_C: begin
               if (w_baud_tick) begin
                  r_baud_cnt <= '0;
                  if (r_bit_idx == BIT_STOP) begin
                     r_bit_idx <= 4'd0;
                     if (r_state == S_TX_C) begin
                        r_sci_tx  <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= S_WAIT_RSP;
                     end else begin
                        // Next byte's start bit follows the stop bit directly.
                        r_sci_tx <= 1'b0;
                        r_state  <= (r_state == S_TX_A) ? S_TX_B : S_TX_C;
                     end
                  end else begin
                     r_bit_idx <= r_bit_idx + 4'd1;
                     r_sci_tx  <= w_next_tx_bit;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + BW'(1);
               end
            end

            S_WAIT_RSP: begin
               if (w_rx_fall) begin
                  r_baud_cnt <= '0;
                  r_bit_idx  <= 4'd0;
                  r_state    <= S_RX_BYTE;
               end else if (w_tmo_hit) begin
                  r_rsp_err   <= ERR_TIMEOUT;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end

            S_RX_BYTE: begin
               if (w_rx_tick) begin
                  r_baud_cnt <= '0;
                  if (r_bit_idx == 4'd0) begin
                     // A start bit that is high again by mid-bit was a glitch.
                     if (r_rx_sync) begin
                        r_state <= S_WAIT_RSP;
                     end else begin
                        r_bit_idx <= 4'd1;
                     end
                  end else if (r_bit_idx == BIT_STOP) begin
                     r_rsp_data  <= r_rx_shift;
                     r_rsp_err   <= r_rx_sync ? ERR_OK : ERR_FRAME;
                     r_rsp_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     // LSB arrives first; after eight shifts d0 sits in bit 0.
                     r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                     r_bit_idx  <= r_bit_idx + 4'd1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + BW'(1);
               end
            end

            S_DONE: begin
               r_cmd_ready <= 1'b1;
               r_state     <= S_IDLE;
            end

            default: begin
               r_cmd_ready <= 1'b1;
               r_sci_tx    <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign cmd_ready = r_cmd_ready;
   assign busy      = ~r_cmd_ready;
   assign sci_tx    = r_sci_tx;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_uart_alu_host.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_host
//
// Drives uart_alu_host with BAUD_DIV=16 and TIMEOUT_CYC=1000. A stand-in for
// the ALU board decodes the three transmitted bytes from the line waveform and
// replies on sci_rx. Expected frames, replies and timing come from plain
// arithmetic on the command fields.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_alu_host;

   localparam int BAUD_DIV    = 16;
   localparam int TIMEOUT_CYC = 1000;
   localparam int BYTE_CYC    = 10 * BAUD_DIV;
   localparam int FRAME_CYC   = 3 * BYTE_CYC;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_a     = 8'h00;
   logic [7:0] cmd_b     = 8'h00;
   logic [2:0] cmd_cs    = 3'd0;
   logic       cmd_cin   = 1'b0;
   logic       sci_rx    = 1'b1;
   logic       cmd_ready;
   logic       sci_tx;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic [1:0] rsp_err;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   int         cyc = 0;             // index of the latest rising edge
   int         rsp_cnt = 0;
   int         last_rsp_cyc = 0;
   logic [7:0] last_rsp_data = 8'h00;
   logic [1:0] last_rsp_err = 2'b00;
   logic       last_rsp_ready = 1'b0;
   int         acc_cnt = 0;
   int         last_acc_edge = 0;
   int         acc_edge = 0;        // accept edge of the latest accept() call
   logic [7:0] held_data = 8'h00;   // value rsp_data should be holding

   uart_alu_host #(
      .BAUD_DIV    (BAUD_DIV),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_cs    (cmd_cs),
      .cmd_cin   (cmd_cin),
      .sci_tx    (sci_tx),
      .sci_rx    (sci_rx),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Accept happens on an edge where valid and ready were both high before it.
   always @(posedge clk) begin
      if (cmd_valid && cmd_ready) begin
         acc_cnt       <= acc_cnt + 1;
         last_acc_edge <= cyc + 1;
      end
   end

   always @(negedge clk) begin
      if (rsp_valid) begin
         rsp_cnt        <= rsp_cnt + 1;
         last_rsp_cyc   <= cyc;
         last_rsp_data  <= rsp_data;
         last_rsp_err   <= rsp_err;
         last_rsp_ready <= cmd_ready;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no end of test, expected finish before 1 ms");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Result the bench's ALU-board stand-in returns for a command.
   function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] cs, input logic cin);
      case (cs)
         3'd0:    return a + b + {7'd0, cin};
         3'd1:    return a - b - {7'd0, cin};
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ~a;
         3'd6:    return {a[6:0], cin};
         default: return b;
      endcase
   endfunction

   // Expected sci_tx level n cycles into the three-byte frame.
   function automatic logic frame_level(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2, input int n);
      logic [7:0] byt;
      int         j;
      case (n / BYTE_CYC)
         0:       byt = b0;
         1:       byt = b1;
         default: byt = b2;
      endcase
      j = (n % BYTE_CYC) / BAUD_DIV;
      if (j == 0) return 1'b0;
      if (j == 9) return 1'b1;
      return byt[j-1];
   endfunction

   // Presents a command and returns on the first falling edge after the accept.
   task automatic accept(input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] cs, input logic cin);
      int n;
      @(negedge clk);
      cmd_a     = a;
      cmd_b     = b;
      cmd_cs    = cs;
      cmd_cin   = cin;
      cmd_valid = 1'b1;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", 32'(cmd_ready), 32'd1);
      acc_edge = cyc + 1;
      @(negedge clk);
   endtask

   // Samples the 30 bit times after the accept and compares with the expected frame.
   // With noise set, cmd_valid and the fields are scrambled while busy.
   task automatic capture_tx(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input bit keep, input bit noise);
      logic [7:0] got [3];
      int         bad;
      int         j;
      logic       lvl;
      bad = 0;
      got[0] = 8'h00;
      got[1] = 8'h00;
      got[2] = 8'h00;
      for (int n = 0; n < FRAME_CYC; n++) begin
         if (n > 0) @(negedge clk);
         lvl = sci_tx;
         if (lvl !== frame_level(a, b, c, n)) bad++;
         j = (n % BYTE_CYC) / BAUD_DIV;
         if ((n % BAUD_DIV) == BAUD_DIV / 2 && j >= 1 && j <= 8) got[n / BYTE_CYC][j-1] = lvl;
         if (!keep) begin
            if (noise) begin
               cmd_valid = 1'($urandom_range(0, 1));
               cmd_a     = 8'($urandom);
               cmd_b     = 8'($urandom);
               cmd_cs    = 3'($urandom);
               cmd_cin   = 1'($urandom);
            end else begin
               cmd_valid = 1'b0;
            end
         end
      end
      if (!keep) cmd_valid = 1'b0;
      check({tag, "_tx_a"}, 32'(got[0]), 32'(a));
      check({tag, "_tx_b"}, 32'(got[1]), 32'(b));
      check({tag, "_tx_ctrl"}, 32'(got[2]), 32'(c));
      check({tag, "_tx_wave_bad_cycles"}, 32'(bad), 32'd0);
      @(negedge clk);
      check({tag, "_tx_idle"}, 32'(sci_tx), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd1);
   endtask

   task automatic uart_send(input logic [7:0] d, input logic stop);
      sci_rx = 1'b0;
      repeat (BAUD_DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         sci_rx = d[i];
         repeat (BAUD_DIV) @(negedge clk);
      end
      sci_rx = stop;
      repeat (BAUD_DIV) @(negedge clk);
      sci_rx = 1'b1;
   endtask

   task automatic wait_rsp(input string tag, input int base,
                           input logic [7:0] exp_d, input logic [1:0] exp_e);
      int n;
      n = 0;
      while (rsp_cnt == base && n < 2500) begin
         @(posedge clk);
         n++;
      end
      repeat (40) @(posedge clk);
      check({tag, "_rsp_count"}, 32'(rsp_cnt - base), 32'd1);
      check({tag, "_rsp_data"}, 32'(last_rsp_data), 32'(exp_d));
      check({tag, "_rsp_err"}, 32'(last_rsp_err), 32'(exp_e));
      check({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      logic [7:0] a, b, r, ctrl;
      logic [2:0] cs;
      logic       cin, stop;
      int         base, abase, lat, n, dly;

      // ---------------- reset values ----------------
      repeat (3) @(negedge clk);
      check("rst_sci_tx", 32'(sci_tx), 32'd1);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'h00);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_ready", 32'(cmd_ready), 32'd1);

      // ---------------- 1: 12 + 34 ----------------
      base = rsp_cnt;
      accept(8'h12, 8'h34, 3'd0, 1'b0);
      capture_tx("t1", 8'h12, 8'h34, 8'h00, 1'b0, 1'b0);
      uart_send(alu_ref(8'h12, 8'h34, 3'd0, 1'b0), 1'b1);
      wait_rsp("t1", base, 8'h46, 2'b00);
      held_data = 8'h46;
      // accept to rsp_valid with an immediate reply: 30*16 + 3 + 152 + 1 = 636, +/-1
      lat = last_rsp_cyc - acc_edge;
      check("t1_latency", 32'((lat >= 635 && lat <= 637) ? 636 : lat), 32'd636);

      // ---------------- 2: FF + 01 + cin ----------------
      base = rsp_cnt;
      accept(8'hFF, 8'h01, 3'd0, 1'b1);
      capture_tx("t2", 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0);
      uart_send(alu_ref(8'hFF, 8'h01, 3'd0, 1'b1), 1'b1);
      wait_rsp("t2", base, 8'h01, 2'b00);
      held_data = 8'h01;

      // ---------------- 3: silent board -> timeout ----------------
      base = rsp_cnt;
      accept(8'hA0, 8'h0B, 3'd4, 1'b0);
      capture_tx("t3", 8'hA0, 8'h0B, 8'h08, 1'b0, 1'b0);
      wait_rsp("t3", base, held_data, 2'b01);
      lat = last_rsp_cyc - acc_edge - FRAME_CYC;
      check("t3_timeout_latency", 32'((lat >= TIMEOUT_CYC - 2 && lat <= TIMEOUT_CYC + 2) ? TIMEOUT_CYC : lat),
            32'(TIMEOUT_CYC));

      // ---------------- 4: framing error ----------------
      base = rsp_cnt;
      accept(8'h33, 8'h27, 3'd7, 1'b0);
      capture_tx("t4", 8'h33, 8'h27, 8'h0E, 1'b0, 1'b0);
      uart_send(8'h5A, 1'b0);
      wait_rsp("t4", base, 8'h5A, 2'b10);
      held_data = 8'h5A;

      // ---------------- 5: 3-cycle glitch then 77 ----------------
      base = rsp_cnt;
      accept(8'h01, 8'h02, 3'd3, 1'b1);
      capture_tx("t5", 8'h01, 8'h02, 8'h07, 1'b0, 1'b0);
      sci_rx = 1'b0;
      repeat (3) @(negedge clk);
      sci_rx = 1'b1;
      repeat (30) @(negedge clk);
      uart_send(8'h77, 1'b1);
      wait_rsp("t5", base, 8'h77, 2'b00);
      held_data = 8'h77;

      // ---------------- 6: reset in the middle of TX_B ----------------
      base = rsp_cnt;
      accept(8'hC3, 8'h3C, 3'd2, 1'b0);
      cmd_valid = 1'b0;
      repeat (220) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t6_tx_high_async", 32'(sci_tx), 32'd1);
      @(negedge clk);
      check("t6_tx_high", 32'(sci_tx), 32'd1);
      check("t6_ready", 32'(cmd_ready), 32'd1);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_rsp_data_cleared", 32'(rsp_data), 32'h00);
      held_data = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("t6_no_rsp", 32'(rsp_cnt - base), 32'd0);
      accept(8'h9C, 8'h41, 3'd0, 1'b0);
      capture_tx("t6b", 8'h9C, 8'h41, 8'h00, 1'b0, 1'b0);
      uart_send(alu_ref(8'h9C, 8'h41, 3'd0, 1'b0), 1'b1);
      wait_rsp("t6b", base, 8'hDD, 2'b00);
      held_data = 8'hDD;

      // ---------------- 7: cmd_valid held across the exchange ----------------
      base  = rsp_cnt;
      abase = acc_cnt;
      accept(8'h10, 8'h20, 3'd3, 1'b0);
      capture_tx("t7", 8'h10, 8'h20, 8'h06, 1'b1, 1'b0);
      uart_send(alu_ref(8'h10, 8'h20, 3'd3, 1'b0), 1'b1);
      n = 0;
      while (acc_cnt < abase + 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      cmd_valid = 1'b0;
      check("t7_second_accept", 32'(acc_cnt - abase), 32'd2);
      check("t7_accept_gap", 32'(last_acc_edge - last_rsp_cyc), 32'd2);
      check("t7_ready_in_done", 32'(last_rsp_ready), 32'd0);
      check("t7_rsp_data", 32'(last_rsp_data), 32'h30);
      held_data = 8'h30;
      // The second command gets no reply and must end in a timeout.
      wait_rsp("t7b", base + 1, held_data, 2'b01);

      // ---------------- 8: byte on sci_rx during TX is discarded ----------------
      base = rsp_cnt;
      accept(8'h55, 8'hAA, 3'd1, 1'b1);
      fork
         capture_tx("t8", 8'h55, 8'hAA, 8'h03, 1'b0, 1'b0);
         begin
            repeat (40) @(negedge clk);
            uart_send(8'h00, 1'b1);
         end
      join
      uart_send(alu_ref(8'h55, 8'hAA, 3'd1, 1'b1), 1'b1);
      wait_rsp("t8", base, 8'hAA, 2'b00);
      held_data = 8'hAA;

      // ---------------- random commands ----------------
      for (int it = 0; it < 6; it++) begin
         a     = 8'($urandom);
         b     = 8'($urandom);
         cs    = 3'($urandom);
         cin   = 1'($urandom);
         stop  = ($urandom_range(0, 3) != 0);
         dly   = $urandom_range(0, 150);
         ctrl  = {4'b0000, cs, cin};
         r     = alu_ref(a, b, cs, cin);
         base  = rsp_cnt;
         abase = acc_cnt;
         accept(a, b, cs, cin);
         capture_tx("rnd", a, b, ctrl, 1'b0, 1'b1);
         repeat (dly) @(negedge clk);
         uart_send(r, stop);
         wait_rsp("rnd", base, r, stop ? 2'b00 : 2'b10);
         check("rnd_single_accept", 32'(acc_cnt - abase), 32'd1);
         held_data = r;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
